present_feeder: RTL and testbench
=================================

# present_feeder

Upstream front end for the iterative PRESENT `Encrypt` core. It assembles 64-bit plaintext blocks from a byte stream and holds the 80-bit cipher key. It drives `Encrypt`'s level-sensitive `Enable` through the load, run and capture sequence, and returns each finished ciphertext on a valid/ready port. It also supplies a round-timeout watchdog and a block counter for system status.

## Interface
- BLOCK_BITS, 64, plaintext/ciphertext width (matches `size).
- KEY_BITS, 80, key width (matches `key_size).
- RUN_LIMIT, 40, maximum RUN cycles before timeout; must be ≥ 33.
- Clock  in  1  single clock for the entire block; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- key_in  in  KEY_BITS  key value.
- key_load  in  1  capture key_in when key_ready=1.
- key_ready  out  1  high only in FILL.
- in_byte  in  8  plaintext byte. The first byte accepted goes to bits [63:56]; the eighth goes to [7:0].
- in_valid  in  1  byte valid.
- in_ready  out  1  high only in FILL.
- orig_key  out  KEY_BITS  to Encrypt; held key register.
- plaintext  out  BLOCK_BITS  to Encrypt; assembled block register.
- Enable  out  1  to Encrypt; high only in RUN.
- ciphertext  in  BLOCK_BITS  from Encrypt.
- Done  in  1  from Encrypt.
- ct_data  out  BLOCK_BITS  captured ciphertext.
- ct_valid  out  1  high in OUT.
- ct_ready  in  1  consumer accepts ct_data.
- timeout_err  out  1  sticky; set on watchdog expiry.
- blocks_done  out  16  count of completed ct handshakes; wraps 0xFFFF→0.

## Operation
- States: FILL, LOAD, RUN, CAPT, OUT, ERR. All states, registers and counters are registered.
- FILL
  - A byte is accepted when in_valid && in_ready. The byte is shifted in as plaintext <= {plaintext[55:0], in_byte}.
  - byte_cnt (3 bits) increments on each accepted byte.
  - On the 8th accept, byte_cnt wraps to 0 and the FSM goes to LOAD.
- Key capture: key_load && key_ready sets orig_key <= key_in. This works in any FILL cycle, including a cycle that also accepts a byte. The key is stable outside FILL.
- LOAD: exactly one cycle with Enable=0, so Encrypt latches the complete plaintext. Next state is RUN.
- RUN
  - Enable=1 and run_cnt increments every cycle.
  - If Done=1 is sampled, go to CAPT. Enable is high on that edge, so Encrypt performs its final key addition.
  - Otherwise, if run_cnt reaches RUN_LIMIT, go to ERR.
- CAPT
  - Enable=0 for one cycle. ct_data <= ciphertext on the exiting edge, and the FSM goes to OUT.
  - Capture happens exactly once. Holding Enable high past the Done edge would re-add round key 31 and corrupt the result.
- OUT
  - ct_valid=1 and ct_data is held stable.
  - On ct_valid && ct_ready: blocks_done increments, FSM goes to FILL.
- ERR
  - timeout_err=1; Enable, in_ready, key_ready and ct_valid are all 0.
  - ERR is exited only by Reset.
- Reset, in any state including mid-RUN
  - FSM returns to FILL; byte_cnt, run_cnt, plaintext, orig_key, ct_data, blocks_done and timeout_err are cleared to 0.
  - Enable=0, ct_valid=0, in_ready=1, key_ready=1 in the first cycle after reset.

## Timing
- Reset values: Enable=0, ct_valid=0, timeout_err=0, blocks_done=0, ct_data=0, plaintext=0, orig_key=0, in_ready=1, key_ready=1.
- Let edge E be the edge that accepts the 8th byte.
  - Cycle after E: LOAD.
  - Next 32 cycles: RUN. Done is seen in the 32nd RUN cycle.
  - Then one CAPT cycle.
  - ct_valid first rises in the cycle 35 cycles after E.
- Minimum block period: 8 FILL + 1 LOAD + 32 RUN + 1 CAPT + 1 OUT = 43 cycles.
- in_ready and key_ready are 0 from LOAD through OUT. Bytes presented then are not consumed.
- ct_ready held high before ct_valid: handshake in the first OUT cycle.
- ct_ready low: OUT holds indefinitely with ct_data unchanged.
- Done arriving in the first RUN cycle is accepted; there is no minimum round check.

## Test plan
- Key 80'h0, bytes 00×8 → ct_valid asserted 35 cycles after the last accept with ct_data=64'h5579C1387B228445; blocks_done=1.
- Key 80'hFFFF_FFFF_FFFF_FFFF_FFFF, bytes FF×8 → ct_data=64'h3333DCD3213210D2.
- Backpressure: ct_ready low for 20 cycles after ct_valid → ct_data stable, in_ready=0 throughout, single blocks_done increment on release. Then a back-to-back second block → correct result.
- Done tied low → ERR after RUN_LIMIT=40 RUN cycles: timeout_err=1, Enable=0, in_ready=0. Reset → all reset values restored.
- Reset asserted in the 10th RUN cycle → next cycle FILL, byte_cnt=0, orig_key=0. A fresh key and block afterwards produce the correct ciphertext.
- key_load and the 8th byte in the same cycle → both captured; the encryption uses the new key. key_load during RUN → ignored, orig_key unchanged.

Source files
------------

// File: rtl/present_feeder_if.sv
// rtl/present_feeder_if.sv - bundle of key, byte-stream, Encrypt-core and ciphertext signals for present_feeder
interface present_feeder_if #(
    parameter int BLOCK_BITS = 64,
    parameter int KEY_BITS   = 80
);
    logic [KEY_BITS-1:0]   key_in;
    logic                  key_load;
    logic                  key_ready;
    logic [7:0]            in_byte;
    logic                  in_valid;
    logic                  in_ready;
    logic [KEY_BITS-1:0]   orig_key;
    logic [BLOCK_BITS-1:0] plaintext;
    logic                  Enable;
    logic [BLOCK_BITS-1:0] ciphertext;
    logic                  Done;
    logic [BLOCK_BITS-1:0] ct_data;
    logic                  ct_valid;
    logic                  ct_ready;
    logic                  timeout_err;
    logic [15:0]           blocks_done;

    modport master (
        input  key_in, key_load, in_byte, in_valid, ciphertext, Done, ct_ready,
        output key_ready, in_ready, orig_key, plaintext, Enable,
               ct_data, ct_valid, timeout_err, blocks_done
    );

    modport slave (
        output key_in, key_load, in_byte, in_valid, ciphertext, Done, ct_ready,
        input  key_ready, in_ready, orig_key, plaintext, Enable,
               ct_data, ct_valid, timeout_err, blocks_done
    );
endinterface

// File: rtl/present_feeder.sv
// rtl/present_feeder.sv - byte-to-block assembler and Enable sequencer for the iterative PRESENT Encrypt core
module present_feeder #(
    parameter int BLOCK_BITS = 64,
    parameter int KEY_BITS   = 80,
    parameter int RUN_LIMIT  = 40
) (
    input  logic           i_clk,
    input  logic           i_rst,
    present_feeder_if.master bus
);
    localparam int RUN_W = $clog2(RUN_LIMIT + 1);

    localparam logic [2:0] S_FILL = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            r_byte_cnt;
    logic [RUN_W-1:0]      r_run_cnt;
    logic [BLOCK_BITS-1:0] r_plaintext;
    logic [KEY_BITS-1:0]   r_orig_key;
    logic [BLOCK_BITS-1:0] r_ct_data;
    logic [15:0]           r_blocks_done;
    logic                  r_timeout_err;

    logic w_fill;
    logic w_accept;

    assign w_fill   = (r_state == S_FILL);
    assign w_accept = w_fill && bus.in_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_FILL;
            r_byte_cnt    <= 3'd0;
            r_run_cnt     <= '0;
            r_plaintext   <= '0;
            r_orig_key    <= '0;
            r_ct_data     <= '0;
            r_blocks_done <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (bus.key_load) begin
                        r_orig_key <= bus.key_in;
                    end
                    if (w_accept) begin
                        r_plaintext <= {r_plaintext[BLOCK_BITS-9:0], bus.in_byte};
                        r_byte_cnt  <= r_byte_cnt + 3'd1;
                        if (r_byte_cnt == 3'd7) begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_run_cnt <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    // Done wins over the watchdog when both land on the same edge
                    r_run_cnt <= r_run_cnt + 1'b1;
                    if (bus.Done) begin
                        r_state <= S_CAPT;
                    end else if (r_run_cnt == RUN_W'(RUN_LIMIT - 1)) begin
                        r_state       <= S_ERR;
                        r_timeout_err <= 1'b1;
                    end
                end
                S_CAPT: begin
                    r_ct_data <= bus.ciphertext;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (bus.ct_ready) begin
                        r_blocks_done <= r_blocks_done + 16'd1;
                        r_state       <= S_FILL;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_fill;
    assign bus.key_ready   = w_fill;
    assign bus.Enable      = (r_state == S_RUN);
    assign bus.ct_valid    = (r_state == S_OUT);
    assign bus.orig_key    = r_orig_key;
    assign bus.plaintext   = r_plaintext;
    assign bus.ct_data     = r_ct_data;
    assign bus.timeout_err = r_timeout_err;
    assign bus.blocks_done = r_blocks_done;
endmodule

// File: tb/tb_present_feeder.sv
// tb/tb_present_feeder.sv - randomized directed bench for present_feeder with a PRESENT-80 reference and Encrypt stand-in
module tb_present_feeder;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_blocks;
    bit   done_en;
    int   done_at;

    present_feeder_if #(.BLOCK_BITS(64), .KEY_BITS(80)) bus ();

    present_feeder #(.BLOCK_BITS(64), .KEY_BITS(80), .RUN_LIMIT(40)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] p;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
            p = '0;
            for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = s[i];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Encrypt stand-in: latches inputs while Enable is low, ciphertext is only meaningful in the cycle after Done
    logic [5:0]  en_cnt;
    logic [63:0] lat_pt;
    logic [79:0] lat_key;
    logic [63:0] stub_ct;

    assign bus.Done       = done_en && bus.Enable && (int'(en_cnt) == done_at);
    assign bus.ciphertext = stub_ct;

    always @(posedge clk) begin
        if (bus.Enable) begin
            en_cnt <= en_cnt + 6'd1;
        end else begin
            en_cnt  <= 6'd0;
            lat_pt  <= bus.plaintext;
            lat_key <= bus.orig_key;
        end
        if (bus.Done) stub_ct <= present_enc(lat_pt, lat_key);
        else          stub_ct <= 64'hA5A5_5A5A_DEAD_BEEF;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".Enable"},      80'(bus.Enable),      80'd0);
        chk({tag, ".ct_valid"},    80'(bus.ct_valid),    80'd0);
        chk({tag, ".timeout_err"}, 80'(bus.timeout_err), 80'd0);
        chk({tag, ".blocks_done"}, 80'(bus.blocks_done), 80'd0);
        chk({tag, ".ct_data"},     80'(bus.ct_data),     80'd0);
        chk({tag, ".plaintext"},   80'(bus.plaintext),   80'd0);
        chk({tag, ".orig_key"},    bus.orig_key,         80'd0);
        chk({tag, ".in_ready"},    80'(bus.in_ready),    80'd1);
        chk({tag, ".key_ready"},   80'(bus.key_ready),   80'd1);
    endtask

    // Called at a negedge in FILL; returns at the negedge of the cycle after the 8th accept
    task automatic send_block(input logic [79:0] key, input logic [63:0] pt, input bit key_last, input bit gaps);
        if (!key_last) begin
            bus.key_in   = key;
            bus.key_load = 1'b1;
            @(negedge clk);
            bus.key_load = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            bus.in_byte  = pt[63 - 8*b -: 8];
            bus.in_valid = 1'b1;
            if (key_last && b == 7) begin
                bus.key_in   = key;
                bus.key_load = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.key_load = 1'b0;
    endtask

    task automatic wait_ct(output int lat);
        lat = 1;
        while (!bus.ct_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [79:0] key, input logic [63:0] pt,
                             input bit key_last, input bit gaps, input int exp_lat);
        int lat;
        send_block(key, pt, key_last, gaps);
        wait_ct(lat);
        chk({tag, ".latency"}, 80'(lat), 80'(exp_lat));
        chk({tag, ".ct_data"}, 80'(bus.ct_data), 80'(present_enc(pt, key)));
        @(negedge clk);
        exp_blocks++;
        chk({tag, ".blocks_done"}, 80'(bus.blocks_done), 80'(exp_blocks));
        chk({tag, ".ct_valid_drop"}, 80'(bus.ct_valid), 80'd0);
    endtask

    initial begin
        logic [79:0] k;
        logic [63:0] pt;
        int lat;
        int cnt;
        total = 0;
        bad = 0;
        exp_blocks = 0;
        done_en = 1'b1;
        done_at = 31;
        rst = 1'b1;
        bus.key_in = '0;
        bus.key_load = 1'b0;
        bus.in_byte = 8'h00;
        bus.in_valid = 1'b0;
        bus.ct_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // Published vectors confirm the reference model itself
        chk("model_zero", 80'(present_enc(64'h0, 80'h0)), 80'h5579C1387B228445);
        chk("model_ones", 80'(present_enc(64'hFFFF_FFFF_FFFF_FFFF, {80{1'b1}})), 80'h3333DCD3213210D2);

        run_block("zero", 80'h0, 64'h0, 1'b0, 1'b0, 35);
        chk("zero.const", 80'(dut.bus.ct_data), 80'h5579C1387B228445);
        run_block("ones", {80{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 35);
        chk("ones.const", 80'(bus.ct_data), 80'h3333DCD3213210D2);

        // Backpressure: consumer stalls for 20 cycles while junk bytes are offered
        bus.ct_ready = 1'b0;
        k  = {$urandom, $urandom, 16'($urandom)};
        pt = {$urandom, $urandom};
        send_block(k, pt, 1'b0, 1'b1);
        wait_ct(lat);
        chk("bp.latency", 80'(lat), 80'd35);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = 8'($urandom);
            @(negedge clk);
            chk("bp.ct_data_hold", 80'(bus.ct_data), 80'(present_enc(pt, k)));
            chk("bp.in_ready", 80'(bus.in_ready), 80'd0);
            chk("bp.blocks_hold", 80'(bus.blocks_done), 80'(exp_blocks));
        end
        bus.in_valid = 1'b0;
        bus.ct_ready = 1'b1;
        @(negedge clk);
        exp_blocks++;
        chk("bp.release_blocks", 80'(bus.blocks_done), 80'(exp_blocks));
        chk("bp.release_fill", 80'(bus.in_ready), 80'd1);
        run_block("b2b", {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1'b0, 1'b0, 35);

        // Key loaded on the same edge as the 8th byte must be the one used
        k = {$urandom, $urandom, 16'($urandom)};
        run_block("key_last", k, {$urandom, $urandom}, 1'b1, 1'b0, 35);
        chk("key_last.orig_key", bus.orig_key, k);

        // key_load outside FILL is ignored
        pt = {$urandom, $urandom};
        send_block(k ^ {80{1'b1}}, pt, 1'b0, 1'b0);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        wait_ct(lat);
        chk("run_key.orig_key", bus.orig_key, k ^ {80{1'b1}});
        chk("run_key.ct_data", 80'(bus.ct_data), 80'(present_enc(pt, k ^ {80{1'b1}})));
        bus.key_load = 1'b0;
        @(negedge clk);
        exp_blocks++;
        chk("run_key.blocks_done", 80'(bus.blocks_done), 80'(exp_blocks));

        // Done in the very first RUN cycle
        done_at = 0;
        run_block("early_done", {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1'b0, 1'b1, 4);
        done_at = 31;

        for (int i = 0; i < 4; i++) begin
            run_block("rand", {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom},
                      1'($urandom), 1'b1, 35);
        end

        // Reset in the 10th RUN cycle
        send_block({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        chk("midrun.enable", 80'(bus.Enable), 80'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_blocks = 0;
        chk_reset_vals("midrun");
        run_block("after_midrun", {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1'b0, 1'b1, 35);

        // Watchdog: Done never comes
        done_en = 1'b0;
        send_block({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1'b0, 1'b0);
        cnt = 0;
        lat = 0;
        while (!bus.timeout_err && lat < 200) begin
            @(negedge clk);
            if (bus.Enable) cnt++;
            lat++;
        end
        chk("tmo.run_cycles", 80'(cnt), 80'd40);
        chk("tmo.err", 80'(bus.timeout_err), 80'd1);
        chk("tmo.enable", 80'(bus.Enable), 80'd0);
        chk("tmo.in_ready", 80'(bus.in_ready), 80'd0);
        chk("tmo.key_ready", 80'(bus.key_ready), 80'd0);
        chk("tmo.ct_valid", 80'(bus.ct_valid), 80'd0);
        bus.in_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("tmo.sticky", 80'(bus.timeout_err), 80'd1);
        chk("tmo.stuck", 80'(bus.in_ready), 80'd0);
        bus.in_valid = 1'b0;
        done_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_blocks = 0;
        chk_reset_vals("tmo_reset");
        run_block("after_tmo", {$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1'b0, 1'b0, 35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
